// File: rtl/spi_master_tx_pkg.sv
// -----------------------------------------------------------------------------
// spi_master_tx_pkg
// Definitions shared by the SPI blocks: the frame FSM state type and the SPI
// mode constants. The future SPI slave receiver is meant to reuse this package.
// -----------------------------------------------------------------------------
package spi_master_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  // Mode 0: sclk idles low, data sampled on the rising edge.
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_master_tx_if.sv
// -----------------------------------------------------------------------------
// spi_master_tx_if
// Groups the upstream valid/ready word handshake, the SPI pad signals and the
// received-word outputs of spi_master_tx.
//   master modport : the SPI master side (drives ready, SPI outputs, rx results)
//   slave  modport : the environment side (drives valid, data, miso)
// -----------------------------------------------------------------------------
interface spi_master_tx_if #(
  parameter int P_DATA_WIDTH = 8
);
  logic                    valid;
  logic [P_DATA_WIDTH-1:0] data;
  logic                    ready;
  logic                    sclk;
  logic                    cs_n;
  logic                    mosi;
  logic                    miso;
  logic [P_DATA_WIDTH-1:0] rx_data;
  logic                    rx_valid;
  logic                    busy;

  modport master (
    input  valid, data, miso,
    output ready, sclk, cs_n, mosi, rx_data, rx_valid, busy
  );

  modport slave (
    output valid, data, miso,
    input  ready, sclk, cs_n, mosi, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/spi_master_tx_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_master_tx_clk_gen
// Half-period divider for the SPI clock. Counts 0..P_CLK_DIV-1 while enabled
// and reloads every half period.
//   clk_100       in  system clock
//   s_rst         in  synchronous active-high reset
//   i_en          in  divider running (frame in progress)
//   i_clr         in  restart the divider (entry to SETUP)
//   i_toggle      in  the current half-period ends with an sclk edge
//   i_sclk        in  current sclk level, selects rise or fall strobe
//   o_tick        out last cycle of a half period
//   o_sclk_rise   out tick that turns sclk high
//   o_sclk_fall   out tick that turns sclk low
// -----------------------------------------------------------------------------
module spi_master_tx_clk_gen #(
  parameter int P_CLK_DIV = 4
) (
  input  logic clk_100,
  input  logic s_rst,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_toggle,
  input  logic i_sclk,
  output logic o_tick,
  output logic o_sclk_rise,
  output logic o_sclk_fall
);

  localparam int              CW   = (P_CLK_DIV > 1) ? $clog2(P_CLK_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(P_CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_100) begin
    if (s_rst || i_clr || !i_en) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick      = i_en && (r_cnt == LAST);
  assign o_sclk_rise = o_tick && i_toggle && !i_sclk;
  assign o_sclk_fall = o_tick && i_toggle &&  i_sclk;

endmodule

// File: rtl/spi_master_tx.sv
// -----------------------------------------------------------------------------
// spi_master_tx
// SPI mode-0 master. Accepts one word per frame over valid/ready, shifts it out
// MSB-first on mosi with a divided sclk inside a cs_n frame, and captures miso
// on every rising sclk edge into rx_data (strobed by rx_valid).
//   clk_100   in   system clock
//   s_rst     in   synchronous active-high reset, aborts a frame in progress
//   bus       if   spi_master_tx_if.master: valid/data/ready handshake,
//                  sclk/cs_n/mosi/miso pads, rx_data/rx_valid, busy
// Frame: SETUP (P_CLK_DIV cycles) -> SHIFT (2*P_DATA_WIDTH half periods)
//        -> HOLD (P_CLK_DIV cycles) -> IDLE.
// -----------------------------------------------------------------------------
module spi_master_tx
  import spi_master_tx_pkg::*;
#(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_CLK_DIV    = 4
) (
  input  logic                  clk_100,
  input  logic                  s_rst,
  spi_master_tx_if.master       bus
);

  localparam int            BW       = $clog2(P_DATA_WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(P_DATA_WIDTH);

  spi_state_t              r_state;
  logic [P_DATA_WIDTH-1:0] r_tx_sr;
  logic [P_DATA_WIDTH-1:0] r_rx_sr;
  logic [P_DATA_WIDTH-1:0] r_rx_data;
  logic [BW-1:0]           r_bit;
  logic                    r_ready;
  logic                    r_sclk;
  logic                    r_cs_n;
  logic                    r_busy;
  logic                    r_mosi;
  logic                    r_rx_valid;

  logic w_accept;
  logic w_more;
  logic w_toggle;
  logic w_tick;
  logic w_rise;
  logic w_fall;

  assign w_accept = (r_state == IDLE) && r_ready && bus.valid;
  // r_bit counts rising edges already issued; once all are out, the final
  // low half period ends without an edge and hands over to HOLD.
  assign w_more   = (r_bit != LAST_BIT);
  assign w_toggle = (r_state == SETUP) || ((r_state == SHIFT) && (r_sclk || w_more));

  spi_master_tx_clk_gen #(
    .P_CLK_DIV (P_CLK_DIV)
  ) u_clk_gen (
    .clk_100     (clk_100),
    .s_rst       (s_rst),
    .i_en        (r_state != IDLE),
    .i_clr       (w_accept),
    .i_toggle    (w_toggle),
    .i_sclk      (r_sclk),
    .o_tick      (w_tick),
    .o_sclk_rise (w_rise),
    .o_sclk_fall (w_fall)
  );

  always_ff @(posedge clk_100) begin
    if (s_rst) begin
      r_state    <= IDLE;
      r_ready    <= 1'b0;
      r_sclk     <= CPOL;
      r_cs_n     <= 1'b1;
      r_busy     <= 1'b0;
      r_mosi     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_bit      <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          r_cs_n  <= 1'b1;
          r_busy  <= 1'b0;
          r_sclk  <= CPOL;
          r_mosi  <= 1'b0;
          if (w_accept) begin
            r_state <= SETUP;
            r_ready <= 1'b0;
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_mosi  <= bus.data[P_DATA_WIDTH-1];
            r_bit   <= '0;
          end
        end
        SETUP: begin
          if (w_rise) begin
            r_state <= SHIFT;
            r_sclk  <= 1'b1;
            r_bit   <= r_bit + 1'b1;
          end
        end
        SHIFT: begin
          if (w_rise) begin
            r_sclk <= 1'b1;
            r_bit  <= r_bit + 1'b1;
          end else if (w_fall) begin
            r_sclk <= 1'b0;
            // After the last fall mosi keeps presenting the LSB.
            if (w_more) begin
              r_mosi <= r_tx_sr[P_DATA_WIDTH-2];
            end
          end else if (w_tick) begin
            r_state    <= HOLD;
            r_rx_data  <= r_rx_sr;
            r_rx_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (w_tick) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_cs_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_mosi  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Shift registers carry data only; every frame reloads or fully refills them.
  always_ff @(posedge clk_100) begin
    if (w_accept) begin
      r_tx_sr <= bus.data;
    end else if (w_fall && w_more) begin
      r_tx_sr <= r_tx_sr << 1;
    end
    if (w_rise) begin
      r_rx_sr <= {r_rx_sr[P_DATA_WIDTH-2:0], bus.miso};
    end
  end

  assign bus.ready    = r_ready;
  assign bus.sclk     = r_sclk;
  assign bus.cs_n     = r_cs_n;
  assign bus.busy     = r_busy;
  assign bus.mosi     = r_mosi;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_master_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_master_tx
// Directed bench for spi_master_tx. A frame-timeline model predicts every
// output from the cycle offset since acceptance; literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_spi_master_tx;

  localparam int W       = 8;
  localparam int P       = 4;
  localparam int HOLD_K  = P + 2*W*P + 1;      // first HOLD cycle offset
  localparam int LAT     = (2*W + 2) * P;      // cycles ready stays low

  logic clk_100 = 1'b0;
  logic s_rst   = 1'b1;
  logic miso_loop  = 1'b1;
  logic miso_const = 1'b0;
  bit   chk_en     = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  spi_master_tx_if #(.P_DATA_WIDTH(W)) sif ();

  assign sif.miso = miso_loop ? sif.mosi : miso_const;

  spi_master_tx #(
    .P_DATA_WIDTH (W),
    .P_CLK_DIV    (P)
  ) dut (
    .clk_100 (clk_100),
    .s_rst   (s_rst),
    .bus     (sif.master)
  );

  always #5 clk_100 = ~clk_100;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- model: frame timeline ----------------
  int         m_k     = 0;
  bit         m_inrst = 1'b1;
  logic [W-1:0] m_word = '0;
  logic [W-1:0] m_exp  = '0;
  logic [W-1:0] m_rxd  = '0;

  initial begin
    forever begin
      @(posedge clk_100);
      if (s_rst) begin
        m_inrst = 1'b1;
        m_k     = 0;
        m_rxd   = '0;
      end else if (m_k == 0) begin
        if (!m_inrst && sif.valid) begin
          m_k    = 1;
          m_word = sif.data;
          m_exp  = miso_loop ? sif.data : {W{miso_const}};
        end
        m_inrst = 1'b0;
      end else begin
        m_k = (m_k == LAT) ? 0 : m_k + 1;
        if (m_k == HOLD_K) m_rxd = m_exp;
      end
    end
  end

  // ---------------- compare + monitor ----------------
  logic         prev_sclk = 1'b0, prev_cs_n = 1'b1, prev_ready = 1'b0;
  logic [W-1:0] mon_cap = '0, last_cap = '0, last_rx = '0, prev_rx = '0;
  int           mon_rises = 0, last_rises = 0, rxv_total = 0;
  int           low_cnt = 0, last_low = 0, hi_cnt = 0, last_gap = 0;
  logic         mosi_or = 1'b0, last_mosi_or = 1'b0;

  initial begin
    forever begin
      @(negedge clk_100);
      if (chk_en) begin
        logic e_sclk, e_mosi;
        int   j, idx;
        e_sclk = 1'b0;
        e_mosi = 1'b0;
        if (m_k >= 1 && m_k <= P) e_mosi = m_word[W-1];
        if (m_k > P && m_k < HOLD_K) begin
          j      = (m_k - P - 1) / P;
          e_sclk = (j % 2 == 0);
          idx    = (j + 1) / 2;
          if (idx > W-1) idx = W-1;
          e_mosi = m_word[W-1-idx];
        end
        check("ready",    sif.ready,    !m_inrst && m_k == 0);
        check("cs_n",     sif.cs_n,     m_k == 0);
        check("busy",     sif.busy,     m_k != 0);
        check("sclk",     sif.sclk,     e_sclk);
        if (m_k < HOLD_K) check("mosi", sif.mosi, e_mosi);
        check("rx_valid", sif.rx_valid, m_k == HOLD_K);
        check("rx_data",  sif.rx_data,  m_rxd);
      end
      // Monitor for the literal checks in the directed tests.
      if (prev_cs_n && !sif.cs_n) begin
        last_gap  = hi_cnt;
        hi_cnt    = 0;
        mon_cap   = '0;
        mon_rises = 0;
        mosi_or   = 1'b0;
      end
      if (sif.cs_n) hi_cnt++;
      else          mosi_or = mosi_or | sif.mosi;
      if (sif.sclk && !prev_sclk) begin
        mon_cap = {mon_cap[W-2:0], sif.mosi};
        mon_rises++;
      end
      if (sif.rx_valid) begin
        last_cap     = mon_cap;
        last_rises   = mon_rises;
        prev_rx      = last_rx;
        last_rx      = sif.rx_data;
        last_mosi_or = mosi_or;
        rxv_total++;
      end
      if (!sif.ready) low_cnt++;
      else if (!prev_ready) begin
        last_low = low_cnt;
        low_cnt  = 0;
      end
      prev_sclk  = sif.sclk;
      prev_cs_n  = sif.cs_n;
      prev_ready = sif.ready;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_100);
    #1;
  endtask

  task automatic wait_ready(input logic lvl, input string name);
    int n = 0;
    while (sif.ready !== lvl && n < 300) begin
      step();
      n++;
    end
    if (sif.ready !== lvl) timeout_fail(name);
  endtask

  // Waits for ready to be seen high, then for the acceptance (ready low).
  task automatic wait_accept(input string name);
    wait_ready(1'b1, {name, "_ready"});
    wait_ready(1'b0, {name, "_accept"});
  endtask

  task automatic wait_strobes(input int target, input string name);
    int n = 0;
    while (rxv_total < target && n < 400) begin
      step();
      n++;
    end
    if (rxv_total < target) timeout_fail(name);
  endtask

  task automatic send(input logic [W-1:0] word, input string name);
    sif.valid = 1'b1;
    sif.data  = word;
    wait_accept(name);
    sif.valid = 1'b0;
  endtask

  task automatic finish_frame(input int target, input string name);
    wait_strobes(target, {name, "_strobe"});
    wait_ready(1'b1, {name, "_idle"});
    step();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int base;
    sif.valid = 1'b0;
    sif.data  = '0;
    repeat (3) step();
    chk_en = 1'b1;

    // 1: reset behaviour
    check("rst_ready", sif.ready, 0);
    check("rst_cs_n",  sif.cs_n,  1);
    check("rst_sclk",  sif.sclk,  0);
    check("rst_mosi",  sif.mosi,  0);
    s_rst = 1'b0;
    step();
    check("post_rst_ready", sif.ready, 1);
    repeat (3) step();
    s_rst = 1'b1;
    repeat (2) step();
    check("mid_rst_ready", sif.ready, 0);
    check("mid_rst_cs_n",  sif.cs_n,  1);
    s_rst = 1'b0;
    step();
    check("mid_post_ready", sif.ready, 1);
    repeat (2) step();

    // 2: single word, loopback
    base = rxv_total;
    send(8'hA5, "t2");
    finish_frame(base + 1, "t2");
    check("t2_rises",     last_rises, 8);
    check("t2_mosi_bits", last_cap,   8'hA5);
    check("t2_rx",        last_rx,    8'hA5);
    check("t2_strobes",   rxv_total - base, 1);
    check("t2_ready_low", last_low,   72);

    // 3: valid with no ready mid-frame
    base = rxv_total;
    send(8'hA5, "t3a");
    repeat (20) step();
    sif.valid = 1'b1;
    sif.data  = 8'h3C;
    wait_strobes(base + 1, "t3a_strobe");
    check("t3_inflight_bits", last_cap, 8'hA5);
    check("t3_inflight_rx",   last_rx,  8'hA5);
    wait_accept("t3b");
    sif.valid = 1'b0;
    finish_frame(base + 2, "t3b");
    check("t3_late_bits", last_cap, 8'h3C);
    check("t3_late_rx",   last_rx,  8'h3C);

    // 4: back-to-back with valid held
    base = rxv_total;
    sif.valid = 1'b1;
    sif.data  = 8'h01;
    wait_accept("t4a");
    sif.data  = 8'h02;
    wait_accept("t4b");
    sif.valid = 1'b0;
    finish_frame(base + 2, "t4");
    check("t4_strobes", rxv_total - base, 2);
    check("t4_rx_first",  prev_rx, 8'h01);
    check("t4_rx_second", last_rx, 8'h02);
    check("t4_gap_ok",    last_gap >= 1, 1);

    // 5: abort mid-frame
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    repeat (2) step();
    base = rxv_total;
    send(8'hFF, "t5a");
    begin
      int n = 0;
      while (mon_rises < 3 && n < 200) begin
        step();
        n++;
      end
      if (mon_rises < 3) timeout_fail("t5_third_rise");
    end
    s_rst = 1'b1;
    step();
    check("t5_abort_cs_n", sif.cs_n, 1);
    check("t5_abort_sclk", sif.sclk, 0);
    s_rst = 1'b0;
    repeat (100) step();
    check("t5_no_strobe", rxv_total - base, 0);
    check("t5_rx_kept",   sif.rx_data, 8'h00);
    send(8'h5A, "t5b");
    finish_frame(base + 1, "t5b");
    check("t5_clean_bits",  last_cap,   8'h5A);
    check("t5_clean_rx",    last_rx,    8'h5A);
    check("t5_clean_rises", last_rises, 8);

    // 6: miso stuck high, zero word
    miso_loop  = 1'b0;
    miso_const = 1'b1;
    base = rxv_total;
    send(8'h00, "t6");
    finish_frame(base + 1, "t6");
    check("t6_rx",      last_rx,      8'hFF);
    check("t6_mosi_lo", last_mosi_or, 0);

    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
